// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light countdown display path.
package traffic_pkg;

  typedef enum logic [1:0] {RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2, BAD = 2'd3} colour_t;
  typedef enum logic [1:0] {NORMAL = 2'd0, FAULT = 2'd1, RECOVER = 2'd2} fsm_t;

  localparam logic [2:0] LAMP_RED    = 3'b011;
  localparam logic [2:0] LAMP_YELLOW = 3'b101;
  localparam logic [2:0] LAMP_GREEN  = 3'b110;

  // Controller output vectors, road A in [5:3], road B in [2:0], active-low
  localparam logic [5:0] LV_AG_BR = 6'b110_011;
  localparam logic [5:0] LV_AY_BR = 6'b101_011;
  localparam logic [5:0] LV_AR_BR = 6'b011_011;
  localparam logic [5:0] LV_AR_BG = 6'b011_110;
  localparam logic [5:0] LV_AR_BY = 6'b011_101;
  localparam logic [5:0] LV_DARK  = 6'b111_111;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic colour_t decode_group(input logic [2:0] grp);
    case (grp)
      LAMP_RED:    decode_group = RED;
      LAMP_YELLOW: decode_group = YELLOW;
      LAMP_GREEN:  decode_group = GREEN;
      default:     decode_group = BAD;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(input int unsigned val);
    to_bcd = {4'(val / 32'd10), 4'(val % 32'd10)};
  endfunction

  // Caller guarantees a nonzero count, so the tens digit never underflows
  function automatic logic [7:0] bcd_dec(input logic [7:0] cnt);
    if (cnt[3:0] == 4'd0) bcd_dec = {cnt[7:4] - 4'd1, 4'd9};
    else                  bcd_dec = {cnt[7:4], cnt[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/traffic_countdown_bcd_to_seg.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segment decoder with blanking.
module bcd_to_seg
  import traffic_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // Digit lookup; non-BCD codes blank rather than show garbage
  always_comb begin
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (bcd)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/traffic_countdown.sv
// Per-road BCD countdown of seconds left in the current colour, with
// illegal-lamp detection that blanks the display until two legal ticks.
module traffic_countdown
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 10,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned RED_TICKS    = 18
) (
  input  logic       clk1h,
  input  logic       rst_n,
  input  logic [5:0] lights,
  output logic [6:0] seg_a_tens,
  output logic [6:0] seg_a_ones,
  output logic [6:0] seg_b_tens,
  output logic [6:0] seg_b_ones,
  output logic       fault
);

  if (GREEN_TICKS < 1 || GREEN_TICKS > 99 || YELLOW_TICKS < 1 || YELLOW_TICKS > 99 ||
      RED_TICKS < 1 || RED_TICKS > 99) begin : g_bad_ticks
    $error("traffic_countdown: tick parameters must be within 1..99");
  end

  localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_TICKS);
  localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_TICKS);
  localparam logic [7:0] RED_BCD    = to_bcd(RED_TICKS);

  logic [5:0]      lights_q_r;
  fsm_t            state_r;
  fsm_t            state_nxt_s;
  logic [1:0][7:0] cnt_r;
  logic [1:0][7:0] cnt_nxt_s;
  colour_t         col_s   [2];
  colour_t         col_q_s [2];
  logic            legal_s;
  logic            blank_s;
  logic [6:0]      seg_s   [4];

  // Index 0 is road A, index 1 is road B
  always_comb begin
    col_s[0]   = decode_group(lights[5:3]);
    col_s[1]   = decode_group(lights[2:0]);
    col_q_s[0] = decode_group(lights_q_r[5:3]);
    col_q_s[1] = decode_group(lights_q_r[2:0]);
    legal_s    = (col_s[0] != BAD) && (col_s[1] != BAD) &&
                 ((col_s[0] == RED) || (col_s[1] == RED));
  end

  // Fault FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      NORMAL:  if (legal_s) state_nxt_s = NORMAL;  else state_nxt_s = FAULT;
      FAULT:   if (legal_s) state_nxt_s = RECOVER; else state_nxt_s = FAULT;
      RECOVER: if (legal_s) state_nxt_s = NORMAL;  else state_nxt_s = FAULT;
      default: state_nxt_s = FAULT;
    endcase
    blank_s = (state_nxt_s != NORMAL);
  end

  // Counter next value; reset leaves lights_q dark, so the first legal tick
  // always looks like a colour change, and leaving RECOVER forces a load
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      cnt_nxt_s[r] = cnt_r[r];
      if (blank_s) begin
        cnt_nxt_s[r] = cnt_r[r];
      end else if ((state_r == RECOVER) || (col_s[r] != col_q_s[r])) begin
        case (col_s[r])
          GREEN:   cnt_nxt_s[r] = GREEN_BCD;
          YELLOW:  cnt_nxt_s[r] = YELLOW_BCD;
          RED:     cnt_nxt_s[r] = RED_BCD;
          default: cnt_nxt_s[r] = 8'h00;
        endcase
      end else if (cnt_r[r] != 8'h00) begin
        cnt_nxt_s[r] = bcd_dec(cnt_r[r]);
      end else begin
        cnt_nxt_s[r] = 8'h00;
      end
    end
  end

  bcd_to_seg u_seg_a_tens (.bcd(cnt_nxt_s[0][7:4]), .blank(blank_s || (cnt_nxt_s[0][7:4] == 4'd0)), .seg(seg_s[0]));
  bcd_to_seg u_seg_a_ones (.bcd(cnt_nxt_s[0][3:0]), .blank(blank_s), .seg(seg_s[1]));
  bcd_to_seg u_seg_b_tens (.bcd(cnt_nxt_s[1][7:4]), .blank(blank_s || (cnt_nxt_s[1][7:4] == 4'd0)), .seg(seg_s[2]));
  bcd_to_seg u_seg_b_ones (.bcd(cnt_nxt_s[1][3:0]), .blank(blank_s), .seg(seg_s[3]));

  // State, sample and output registers
  always_ff @(posedge clk1h) begin
    if (!rst_n) begin
      lights_q_r <= LV_DARK;
      state_r    <= NORMAL;
      cnt_r      <= '0;
      seg_a_tens <= SEG_BLANK;
      seg_a_ones <= SEG_BLANK;
      seg_b_tens <= SEG_BLANK;
      seg_b_ones <= SEG_BLANK;
      fault      <= 1'b0;
    end else begin
      lights_q_r <= lights;
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      seg_a_tens <= seg_s[0];
      seg_a_ones <= seg_s[1];
      seg_b_tens <= seg_s[2];
      seg_b_ones <= seg_s[3];
      fault      <= blank_s;
    end
  end

endmodule

// File: tb/tb_traffic_countdown.sv
// Scoreboard bench: an integer reference model pushes expected display words
// when each tick is driven; they are popped and compared after the edge.
module tb_traffic_countdown;

  localparam int G_T = 10;
  localparam int Y_T = 3;
  localparam int R_T = 18;

  typedef struct packed {
    logic [6:0] a_tens;
    logic [6:0] a_ones;
    logic [6:0] b_tens;
    logic [6:0] b_ones;
    logic       flt;
  } disp_t;

  logic       clk1h = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] lights = 6'b110011;
  logic [6:0] seg_a_tens, seg_a_ones, seg_b_tens, seg_b_ones;
  logic       fault;

  int n_cmp = 0;
  int n_bad = 0;
  disp_t sb_q[$];

  // model state: 0 normal, 1 fault, 2 recover
  int         m_state = 0;
  int         m_cnt [2];
  logic [5:0] m_q = 6'b111111;

  traffic_countdown #(.GREEN_TICKS(G_T), .YELLOW_TICKS(Y_T), .RED_TICKS(R_T)) dut (
    .clk1h(clk1h), .rst_n(rst_n), .lights(lights),
    .seg_a_tens(seg_a_tens), .seg_a_ones(seg_a_ones),
    .seg_b_tens(seg_b_tens), .seg_b_ones(seg_b_ones), .fault(fault));

  always #5 clk1h = ~clk1h;

  function automatic logic [6:0] digit_seg(input int d);
    logic [6:0] hi [10];
    hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return ~hi[d];
  endfunction

  function automatic int colour_of(input logic [2:0] g);
    if (g == 3'b011) return 0;
    if (g == 3'b101) return 1;
    if (g == 3'b110) return 2;
    return 3;
  endfunction

  function automatic int ticks_of(input int c);
    if (c == 0) return R_T;
    if (c == 1) return Y_T;
    return G_T;
  endfunction

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_tick(input logic rst, input logic [5:0] l);
    disp_t e;
    int c [2];
    int cq [2];
    int nxt;
    bit legal;
    if (!rst) begin
      m_q = 6'b111111; m_state = 0; m_cnt[0] = 0; m_cnt[1] = 0;
      e = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0};
    end else begin
      c[0] = colour_of(l[5:3]);   c[1] = colour_of(l[2:0]);
      cq[0] = colour_of(m_q[5:3]); cq[1] = colour_of(m_q[2:0]);
      legal = (c[0] != 3) && (c[1] != 3) && (c[0] == 0 || c[1] == 0);
      if (!legal) nxt = 1;
      else if (m_state == 1) nxt = 2;
      else nxt = 0;
      if (nxt == 0) begin
        for (int r = 0; r < 2; r++) begin
          if (m_state == 2 || c[r] != cq[r]) m_cnt[r] = ticks_of(c[r]);
          else if (m_cnt[r] > 0) m_cnt[r] = m_cnt[r] - 1;
        end
        e.a_tens = (m_cnt[0] / 10 == 0) ? 7'h7F : digit_seg(m_cnt[0] / 10);
        e.a_ones = digit_seg(m_cnt[0] % 10);
        e.b_tens = (m_cnt[1] / 10 == 0) ? 7'h7F : digit_seg(m_cnt[1] / 10);
        e.b_ones = digit_seg(m_cnt[1] % 10);
        e.flt    = 1'b0;
      end else begin
        e = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1};
      end
      m_state = nxt;
      m_q = l;
    end
    sb_q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [5:0] l);
    disp_t e;
    @(negedge clk1h);
    rst_n = rst;
    lights = l;
    model_tick(rst, l);
    @(posedge clk1h);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb_q.pop_front();
      check_eq("a_tens", seg_a_tens, e.a_tens);
      check_eq("a_ones", seg_a_ones, e.a_ones);
      check_eq("b_tens", seg_b_tens, e.b_tens);
      check_eq("b_ones", seg_b_ones, e.b_ones);
      check_eq("fault", {6'd0, fault}, {6'd0, e.flt});
    end
  endtask

  initial begin
    logic [5:0] vecs [6];
    logic [5:0] v;
    vecs = '{6'b110011, 6'b101011, 6'b011011, 6'b011110, 6'b011101, 6'b111111};
    m_cnt[0] = 0; m_cnt[1] = 0;

    repeat (2) step(1'b0, 6'b110011);              // reset
    repeat (13) step(1'b1, 6'b110011);             // 10 down to 00, hold 00
    repeat (2) step(1'b1, 6'b101011);              // A yellow, B continues
    step(1'b1, 6'b011110);                          // both reload together
    step(1'b1, 6'b110110);                          // both green: fault
    step(1'b1, 6'b011110);                          // recover
    step(1'b1, 6'b011110);                          // normal, reload
    repeat (11) step(1'b1, 6'b011110);             // A 18 -> 07 through 09
    step(1'b0, 6'b011110);                          // reset mid-count
    step(1'b1, 6'b011101);                          // A 18, B 3
    step(1'b0, 6'b011101);
    step(1'b1, 6'b111111);                          // illegal first tick after reset
    step(1'b1, 6'b011011);
    step(1'b1, 6'b011011);
    step(1'b1, 6'b101011);
    step(1'b1, 6'b101101);                          // no red: fault
    step(1'b1, 6'b011011);
    step(1'b1, 6'b100011);                          // illegal while recovering
    repeat (2) step(1'b1, 6'b011011);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) v = 6'($urandom);
      else v = vecs[$urandom_range(0, 4)];
      repeat ($urandom_range(1, 4)) step(1'b1, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
